// File: rtl/cpc_ram_bank_ctrl_if.sv
// CPC edge-connector bus signals seen by the RAM bank controller.
// master = CPU/bus side, slave = bank controller.
`timescale 1ns/1ps
interface cpc_ram_bank_ctrl_if;
  logic       A15;
  logic       A14;
  logic [7:0] D;
  logic       IOREQ_B;
  logic       WR_B;
  logic       RD_B;
  logic       MREQ_B;
  logic       RAMDIS;
  logic       ramcs_b;
  logic [4:0] ramadrhi;
  logic [5:0] bank_q;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output A15, A14, D, IOREQ_B, WR_B, RD_B, MREQ_B,
    input  RAMDIS, ramcs_b, ramadrhi, bank_q, d_out, d_oe
  );

  modport slave (
    input  A15, A14, D, IOREQ_B, WR_B, RD_B, MREQ_B,
    output RAMDIS, ramcs_b, ramadrhi, bank_q, d_out, d_oe
  );
endinterface

// File: rtl/cpc_ram_bank_ctrl.sv
// CPC 6128-style RAM banking: filtered gate-array write capture, bank register, mode decode.
// Optional readback of the bank register via macro CPC_RAM_READBACK_EN.
`timescale 1ns/1ps
module cpc_ram_bank_ctrl #(
  parameter int FILTER_CYC = 2
) (
  input logic                   CLK,
  input logic                   RESET_B,
  cpc_ram_bank_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HOLD} state_t;

  localparam logic [1:0] ARM_LAST = 2'((FILTER_CYC >= 2) ? (FILTER_CYC - 2) : 0);

  state_t     state_q, state_d;
  logic [1:0] arm_cnt_q, arm_cnt_d;
  logic [7:0] cap_q, cap_d;
  logic       cap_a15_q, cap_a15_d;
  logic       pend_q, pend_d;
  logic [5:0] pend_val_q, pend_val_d;
  logic [5:0] bank_q, bank_d;
  logic       iow;
  logic       commit;

  assign iow = !bus.IOREQ_B && !bus.WR_B;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q    <= ST_IDLE;
      arm_cnt_q  <= '0;
      cap_q      <= '0;
      cap_a15_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      cap_q      <= cap_d;
      cap_a15_q  <= cap_a15_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bank_q     <= bank_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    cap_d      = cap_q;
    cap_a15_d  = cap_a15_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bank_d     = bank_q;
    commit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iow && !bus.A15) begin
          cap_d     = bus.D;
          cap_a15_d = 1'b0;
          arm_cnt_d = '0;
          state_d   = (FILTER_CYC <= 1) ? ST_HOLD : ST_ARM;
        end
      end
      ST_ARM: begin
        if (iow) begin
          cap_d = bus.D;
          if (arm_cnt_q >= ARM_LAST) begin
            state_d = ST_HOLD;
          end else begin
            arm_cnt_d = arm_cnt_q + 2'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (iow) begin
          cap_d     = bus.D;
          cap_a15_d = bus.A15;
        end else begin
          state_d = ST_IDLE;
          commit  = (cap_q[7:6] == 2'b11) && !cap_a15_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A commit during a memory cycle is parked so the mapping never changes mid-access;
    // a later commit simply replaces the parked value.
    if (commit) begin
      if (!bus.MREQ_B) begin
        pend_d     = 1'b1;
        pend_val_d = cap_q[5:0];
      end else begin
        bank_d = cap_q[5:0];
        pend_d = 1'b0;
      end
    end else if (pend_q && bus.MREQ_B) begin
      bank_d = pend_val_q;
      pend_d = 1'b0;
    end
  end

  logic [2:0] mode;
  logic [2:0] blk;
  logic [1:0] win;
  logic [1:0] page;
  logic       ext;

  always_comb begin
    mode = bank_q[2:0];
    blk  = bank_q[5:3];
    win  = {bus.A15, bus.A14};
    ext  = 1'b0;
    page = '0;
    case (mode)
      3'd0: ext = 1'b0;
      3'd1, 3'd3: begin
        ext  = (win == 2'd3);
        page = 2'd3;
      end
      3'd2: begin
        ext  = 1'b1;
        page = win;
      end
      default: begin
        ext  = (win == 2'd1);
        page = 2'(mode - 3'd4);
      end
    endcase
  end

  assign bus.RAMDIS   = ext;
  assign bus.ramcs_b  = !(ext && !bus.MREQ_B);
  assign bus.ramadrhi = ext ? {blk, page} : 5'b00000;
  assign bus.bank_q   = bank_q;

`ifdef CPC_RAM_READBACK_EN
  logic [7:0] d_out_q, d_out_d;

  always_comb begin
    d_out_d = {2'b11, bank_q};
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.d_oe  = !bus.IOREQ_B && !bus.RD_B && !bus.A15;
`else
  logic unused_rd_b;
  assign unused_rd_b = bus.RD_B;
  assign bus.d_out   = '0;
  assign bus.d_oe    = 1'b0;
`endif

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Self-checking bench for cpc_ram_bank_ctrl: directed test-plan steps followed by random writes/accesses.
`timescale 1ns/1ps
module tb_cpc_ram_bank_ctrl;

  localparam int FC = 2;

  logic CLK = 1'b0;
  logic RESET_B;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] exp_bank;

  cpc_ram_bank_ctrl_if bus ();

  cpc_ram_bank_ctrl #(.FILTER_CYC(FC)) dut (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Mapping rules expressed directly from the mode table.
  task automatic ref_map(input logic [5:0] b, input logic [1:0] w,
                         output logic hit, output logic [4:0] adr);
    int m;
    int pg;
    m   = int'(b[2:0]);
    hit = 1'b0;
    pg  = 0;
    if (m == 2) begin
      hit = 1'b1; pg = int'(w);
    end else if (m == 1 || m == 3) begin
      hit = (w == 2'd3); pg = 3;
    end else if (m >= 4) begin
      hit = (w == 2'd1); pg = m - 4;
    end
    adr = hit ? 5'((int'(b[5:3]) * 4) + pg) : 5'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_chk(input logic a15, input logic a14, input logic mreq_b);
    logic hit;
    logic [4:0] adr;
    bus.A15 = a15; bus.A14 = a14; bus.MREQ_B = mreq_b;
    #1;
    ref_map(exp_bank, {a15, a14}, hit, adr);
    chk("ramdis", 32'(bus.RAMDIS), 32'(hit));
    chk("ramcs_b", 32'(bus.ramcs_b), 32'(!(hit && !mreq_b)));
    chk("ramadrhi", 32'(bus.ramadrhi), 32'(adr));
    bus.MREQ_B = 1'b1;
    tick();
  endtask

  task automatic io_write(input logic a15, input logic [7:0] d, input int n, input logic mreq_low);
    logic qual;
    bus.A15 = a15; bus.A14 = 1'b1; bus.D = d; bus.MREQ_B = 1'b1;
    bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
    repeat (n) tick();
    bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1;
    if (mreq_low) bus.MREQ_B = 1'b0;
    tick();
    qual = (n >= FC) && (d[7:6] == 2'b11) && !a15;
    if (qual && mreq_low) begin
      chk("pend_hold0", 32'(bus.bank_q), 32'(exp_bank));
      repeat (2) tick();
      chk("pend_hold2", 32'(bus.bank_q), 32'(exp_bank));
      bus.MREQ_B = 1'b1;
      tick();
    end
    bus.MREQ_B = 1'b1;
    if (qual) exp_bank = d[5:0];
    chk("commit", 32'(bus.bank_q), 32'(exp_bank));
  endtask

  initial begin
    RESET_B = 1'b0;
    bus.A15 = 1'b0; bus.A14 = 1'b0; bus.D = '0;
    bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1; bus.RD_B = 1'b1; bus.MREQ_B = 1'b1;
    exp_bank = '0;
    repeat (2) tick();
    chk("rst_bank", 32'(bus.bank_q), 32'h0);
    chk("rst_ramdis", 32'(bus.RAMDIS), 32'h0);
    chk("rst_ramcs_b", 32'(bus.ramcs_b), 32'h1);
    chk("rst_adrhi", 32'(bus.ramadrhi), 32'h0);
    chk("rst_d_out", 32'(bus.d_out), 32'h0);
    chk("rst_d_oe", 32'(bus.d_oe), 32'h0);
    RESET_B = 1'b1;
    tick();

    io_write(1'b0, 8'hC0, 3, 1'b0);
    mem_chk(1'b1, 1'b1, 1'b0);
    io_write(1'b0, 8'hC1, 3, 1'b0);
    mem_chk(1'b1, 1'b1, 1'b0);
    chk("c1_bank", 32'(bus.bank_q), 32'h01);
    mem_chk(1'b0, 1'b1, 1'b0);
    io_write(1'b0, 8'hFE, 3, 1'b0);
    mem_chk(1'b0, 1'b1, 1'b0);
    mem_chk(1'b0, 1'b0, 1'b0);
    chk("fe_bank", 32'(bus.bank_q), 32'h3E);

    io_write(1'b0, 8'hC2, 1, 1'b0);
    chk("glitch_bank", 32'(bus.bank_q), 32'h3E);
    io_write(1'b0, 8'h8F, 3, 1'b0);
    chk("pen_bank", 32'(bus.bank_q), 32'h3E);
    io_write(1'b1, 8'hC3, 3, 1'b0);
    chk("a15_bank", 32'(bus.bank_q), 32'h3E);

    io_write(1'b0, 8'hC5, 3, 1'b1);
    chk("pend_bank", 32'(bus.bank_q), 32'h05);

    // Reset while the write FSM is in HOLD
    bus.A15 = 1'b0; bus.D = 8'hC3; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
    repeat (2) tick();
    RESET_B = 1'b0;
    #1;
    exp_bank = '0;
    chk("rst_hold_bank", 32'(bus.bank_q), 32'h0);
    bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1;
    repeat (2) tick();
    RESET_B = 1'b1;
    repeat (3) tick();
    chk("rst_hold_late", 32'(bus.bank_q), 32'h0);
    mem_chk(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic a15;
      d = 8'($urandom);
      if ($urandom_range(9, 0) < 7) d[7:6] = 2'b11;
      a15 = ($urandom_range(9, 0) < 2);
      io_write(a15, d, int'($urandom_range(4, 1)), 1'($urandom_range(1, 0)));
      for (int w = 0; w < 4; w++) begin
        mem_chk(1'(w >> 1), 1'(w), 1'($urandom_range(1, 0)));
      end
    end

    io_write(1'b0, 8'hD5, 3, 1'b0);
    tick();
    bus.A15 = 1'b0; bus.IOREQ_B = 1'b0; bus.RD_B = 1'b0;
    #1;
`ifdef CPC_RAM_READBACK_EN
    chk("rb_oe", 32'(bus.d_oe), 32'h1);
    chk("rb_data", 32'(bus.d_out), 32'hD5);
    bus.A15 = 1'b1;
    #1;
    chk("rb_oe_a15", 32'(bus.d_oe), 32'h0);
`else
    chk("rb_oe_off", 32'(bus.d_oe), 32'h0);
    chk("rb_data_off", 32'(bus.d_out), 32'h0);
`endif
    bus.IOREQ_B = 1'b1; bus.RD_B = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpc_ram_bank_ctrl.md
# cpc_ram_bank_ctrl

Clocked replacement for the discrete banking logic of the CPC RAM expansion board. It qualifies Z80 I/O writes to the gate-array port (&7Fxx, D7:D6=11) and holds the 6-bit bank/mode register. It decodes CPC 6128 memory modes 0–7 into RAMDIS, SRAM chip select and SRAM high address A18..A14 for a 512K SRAM. It sits between the CPC edge-connector bus and the bs62lv4006 SRAM, in a single CPLD.

## Interface
Parameters:
- FILTER_CYC, 2: consecutive CLK samples with strobe low needed to qualify an I/O write (range 1–3).

Ports:
- CLK  in  1  CPC bus clock (4 MHz); all state on rising edge.
- RESET_B  in  1  Asynchronous, active-low reset; one clock, no other reset.
- A15, A14  in  1 each  CPU address bits.
- D  in  8  CPU data bus.
- IOREQ_B, WR_B, RD_B, MREQ_B  in  1 each  Z80 strobes, active low.
- RAMDIS  out  1  High = internal RAM disabled; expansion serves the cycle.
- ramcs_b  out  1  SRAM chip select, active low.
- ramadrhi  out  5  SRAM A18..A14.
- bank_q  out  6  Committed register {D5..D0}; status/debug.
- d_out  out  8  Readback data.
- d_oe  out  1  Readback drive enable.

## Operation
- Write strobe: iow = !IOREQ_B & !WR_B, sampled each CLK.
- Write FSM states:
  - IDLE: on iow & !A15 → ARM, capture D into cap.
  - ARM: on iow → HOLD (FILTER_CYC=2) and recapture D. On !iow → IDLE, no commit (glitch reject).
  - HOLD: recapture D and A15 every cycle iow holds. On !iow, commit if the last sample had D[7:6]=11 and A15=0, then → IDLE. Otherwise (pen/colour/other gate-array write) → IDLE, no commit.
  - FILTER_CYC=1: IDLE goes straight to HOLD. FILTER_CYC=3: two ARM cycles.
- Commit: bank_q ← cap[5:0].
  - If MREQ_B is low at the commit edge, set pend and apply on the first edge with MREQ_B high; pend clears then.
  - A newer commit overwrites a pending one.
- Decode, combinational from bank_q and live A15:A14. mode=bank_q[2:0], blk=bank_q[5:3], win=A15:A14.
  - mode 0: no remap.
  - mode 1: win 3 → page 3.
  - mode 2: win 0–3 → page = win.
  - mode 3: win 3 → page 3. Win 1 (internal page 3) is not remapped; this is a fixed limitation.
  - modes 4–7: win 1 → page = mode−4.
- ext = remap hit. RAMDIS = ext. ramcs_b = !(ext & !MREQ_B). ramadrhi = {blk, page} when ext, else 5'b00000.
- Reset values:
  - State IDLE, cap=0, pend=0, bank_q=0.
  - RAMDIS=0, ramcs_b=1, ramadrhi=0, d_out=0, d_oe=0.
- Reset asserted mid-FSM aborts any pending or in-flight write. No commit occurs on reset release.

## Timing
- Commit latency: bank_q updates on the first CLK edge that samples iow inactive after qualification, i.e. one cycle after strobe release. With pend, it updates on the first edge sampling MREQ_B high.
- Decode outputs are combinational. New mapping applies to the first memory cycle after bank_q updates. There are no cycles of latency from address to RAMDIS or ramcs_b.
- A gate-array write of FILTER_CYC or more sampled cycles always commits. A Z80 OUT (≥3 cycles low with the internal wait state) always qualifies at FILTER_CYC ≤ 2.
- Reset and commit in the same edge: reset wins.

## Configuration
- CPC_RAM_READBACK_EN defined:
  - d_oe = !IOREQ_B & !RD_B & !A15 & (A14:A8 all 1s is not checked; only A15 decoded).
  - d_out = {2'b11, bank_q}, registered on each CLK edge.
- Not defined: d_oe and d_out are tied to 0, and RD_B is unused.

## Test plan
- Reset, then OUT &7F00,&C0 (3-cycle strobe) → bank_q=000000; memory read at &C000 gives RAMDIS=0, ramcs_b=1.
- OUT &7F00,&C1, then read &C123 with MREQ_B low → RAMDIS=1, ramcs_b=0, ramadrhi=00011. Read &4000 → RAMDIS=0.
- OUT &7F00,&FE (blk 7, mode 6), then access &4000 → ramadrhi=11110, RAMDIS=1. Access &0000 → RAMDIS=0.
- One-cycle iow pulse with D=&C2 at FILTER_CYC=2 → no commit, bank_q unchanged. OUT &7F00,&8F (D7:D6=10) → no commit.
- Force commit with MREQ_B held low → bank_q unchanged until MREQ_B rises, then updates next edge. Assert RESET_B low in HOLD → bank_q=0, FSM IDLE, no later commit.
- CPC_RAM_READBACK_EN: after OUT &7F00,&D5, IN from &7F00 → d_oe=1, d_out=&D5. Read with A15=1 → d_oe=0.
